// File: rtl/sp_sub_pkg.sv
// Shared types and defaults for the shared-subtractor arbiter.
// The tag field is sized for the largest supported requester count (8).
package sp_sub_pkg;

    localparam int unsigned DEF_N_REQ   = 4;
    localparam int unsigned DEF_WIDTH   = 16;
    localparam int unsigned DEF_LATENCY = 2;
    localparam int unsigned TAG_W       = 3;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic             borrow;
    } pipe_entry_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first active requester at or after the pointer,
// wrapping modulo N. Purely combinational so it can front any shared unit.
module rr_arbiter #(
    parameter  int unsigned N     = 4,
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_grant_idx,
    output logic             o_any
);

    function automatic int unsigned wrap_idx(input int unsigned p, input int unsigned k);
        int unsigned s;
        s = p + k;
        return (s >= N) ? (s - N) : s;
    endfunction

    // Scan from the farthest offset down so the closest active requester wins.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any       = 1'b0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            if (i_req[wrap_idx(32'(i_ptr), unsigned'(k))]) begin
                o_grant     = N'(1) << wrap_idx(32'(i_ptr), unsigned'(k));
                o_grant_idx = IDX_W'(wrap_idx(32'(i_ptr), unsigned'(k)));
                o_any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sp_sub_arbiter.sv
// Shares one free-running pipelined subtractor among N_REQ requesters; a tag
// pipeline matched to the unit latency routes each result back to its owner.
module sp_sub_arbiter
    import sp_sub_pkg::*;
#(
    parameter int unsigned N_REQ   = DEF_N_REQ,
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned LATENCY = DEF_LATENCY
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   sub_ce,
    output logic [WIDTH-1:0]       sub_a,
    output logic [WIDTH-1:0]       sub_b,
    input  logic [WIDTH-1:0]       sub_s,
    output logic [N_REQ-1:0]       resp_valid,
    output logic [WIDTH-1:0]       resp_data,
    output logic                   resp_borrow,
    output logic                   busy
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [IDX_W-1:0] r_ptr;
    logic [N_REQ-1:0] w_grant;
    logic [IDX_W-1:0] w_grant_idx;
    logic             w_any;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;
    logic             w_busy_nxt;
    pipe_entry_t      w_entry;
    pipe_entry_t      r_pipe [0:LATENCY];
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_ce;
    logic [N_REQ-1:0] r_resp_valid;
    logic [WIDTH-1:0] r_resp_data;
    logic             r_resp_borrow;
    logic             r_busy;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .i_req       (req_valid),
        .i_ptr       (r_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_any       (w_any)
    );

    assign req_ready   = w_grant;
    assign sub_ce      = r_ce;
    assign sub_a       = r_a;
    assign sub_b       = r_b;
    assign resp_valid  = r_resp_valid;
    assign resp_data   = r_resp_data;
    assign resp_borrow = r_resp_borrow;
    assign busy        = r_busy;

    // Operand mux and the issue-stage entry for the granted requester.
    always_comb begin
        w_sel_a        = req_a[32'(w_grant_idx) * WIDTH +: WIDTH];
        w_sel_b        = req_b[32'(w_grant_idx) * WIDTH +: WIDTH];
        w_entry.valid  = w_any;
        w_entry.tag    = TAG_W'(w_grant_idx);
        w_entry.borrow = (w_sel_a < w_sel_b);
    end

    // Busy is registered: it is the OR of the valid bits the pipeline holds next.
    always_comb begin
        w_busy_nxt = w_any;
        for (int unsigned i = 0; i < LATENCY; i++) begin
            w_busy_nxt = w_busy_nxt | r_pipe[i].valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr         <= '0;
            r_a           <= '0;
            r_b           <= '0;
            r_ce          <= 1'b0;
            r_resp_valid  <= '0;
            r_resp_data   <= '0;
            r_resp_borrow <= 1'b0;
            r_busy        <= 1'b0;
            for (int unsigned i = 0; i <= LATENCY; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_ce <= 1'b1;
            if (w_any) begin
                r_a   <= w_sel_a;
                r_b   <= w_sel_b;
                r_ptr <= (w_grant_idx == IDX_W'(N_REQ - 1)) ? '0 : w_grant_idx + IDX_W'(1);
            end
            r_pipe[0] <= w_entry;
            for (int unsigned i = 1; i <= LATENCY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
            r_resp_valid  <= r_pipe[LATENCY].valid ? (N_REQ'(1) << r_pipe[LATENCY].tag) : '0;
            r_resp_data   <= sub_s;
            r_resp_borrow <= r_pipe[LATENCY].borrow;
            r_busy        <= w_busy_nxt;
        end
    end

endmodule

// File: tb/tb_sp_sub_arbiter.sv
// Scoreboard bench for sp_sub_arbiter: stimulus pushes expected responses,
// an independent negedge monitor pops and compares them.
module tb_sp_sub_arbiter;

    localparam int N   = 4;
    localparam int W   = 16;
    localparam int LAT = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N-1:0]     req_ready;
    logic             sub_ce;
    logic [W-1:0]     sub_a;
    logic [W-1:0]     sub_b;
    logic [W-1:0]     sub_s;
    logic [N-1:0]     resp_valid;
    logic [W-1:0]     resp_data;
    logic             resp_borrow;
    logic             busy;

    always #5 clk = ~clk;

    sp_sub_arbiter #(.N_REQ(N), .WIDTH(W), .LATENCY(LAT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ready   (req_ready),
        .sub_ce      (sub_ce),
        .sub_a       (sub_a),
        .sub_b       (sub_b),
        .sub_s       (sub_s),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .resp_borrow (resp_borrow),
        .busy        (busy)
    );

    // External subtractor unit: LAT register stages behind the operand inputs.
    logic [W-1:0] u_s [LAT];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) u_s[i] <= '0;
        end else if (sub_ce) begin
            u_s[0] <= sub_a - sub_b;
            for (int i = 1; i < LAT; i++) u_s[i] <= u_s[i-1];
        end
    end
    assign sub_s = u_s[LAT-1];

    typedef struct {
        int owner;
        int data;
        bit borrow;
        int due;
    } exp_t;

    exp_t         sb[$];
    int           checks   = 0;
    int           failures = 0;
    int           cyc      = 0;
    int           m_ptr    = 0;
    int           granted  = -1;
    bit           mon_en   = 0;
    logic [N-1:0] tb_v;
    logic [W-1:0] tb_a [N];
    logic [W-1:0] tb_b [N];
    bit           pend [N];
    exp_t         mon_e;
    bit           mon_busy;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] rand_op();
        int unsigned sel;
        sel = $urandom_range(0, 3);
        if (sel == 0) return '0;
        if (sel == 1) return '1;
        return W'($urandom);
    endfunction

    // One cycle of stimulus, called just after a rising edge.
    task automatic cycle_go();
        int   g;
        int   idx;
        exp_t e;
        req_valid = tb_v;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = tb_a[i];
            req_b[i*W +: W] = tb_b[i];
        end
        #3;
        g = -1;
        for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (tb_v[idx] && g < 0) g = idx;
        end
        check("req_ready", longint'(req_ready), (g < 0) ? 0 : (longint'(1) << g));
        if (g >= 0) begin
            e.owner  = g;
            e.data   = (int'(tb_a[g]) - int'(tb_b[g]) + (1 << W)) % (1 << W);
            e.borrow = (tb_a[g] < tb_b[g]);
            e.due    = cyc + LAT + 2;
            sb.push_back(e);
            m_ptr = (g + 1) % N;
        end
        granted = g;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tb_v      = '0;
        req_valid = '0;
        rst_n     = 1'b0;
        sb.delete();
        m_ptr = 0;
        #2;
        check("rst_resp_valid", longint'(resp_valid), 0);
        check("rst_resp_data", longint'(resp_data), 0);
        check("rst_resp_borrow", longint'(resp_borrow), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_sub_ce", longint'(sub_ce), 0);
        check("rst_sub_a", longint'(sub_a), 0);
        check("rst_sub_b", longint'(sub_b), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: compares every presented response and the busy flag each cycle.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            mon_busy = 0;
            foreach (sb[i]) begin
                if (sb[i].due - LAT - 1 <= cyc && cyc < sb[i].due) mon_busy = 1;
            end
            check("busy", longint'(busy), longint'(mon_busy));
            if (resp_valid != '0) begin
                if (sb.size() == 0) begin
                    check("unexpected_resp", longint'(resp_valid), 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("resp_owner", longint'(resp_valid), longint'(1) << mon_e.owner);
                    check("resp_data", longint'(resp_data), longint'(mon_e.data));
                    check("resp_borrow", longint'(resp_borrow), longint'(mon_e.borrow));
                    check("resp_cycle", longint'(cyc), longint'(mon_e.due));
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                mon_e = sb.pop_front();
                check("resp_missing", longint'(resp_valid), longint'(1) << mon_e.owner);
            end
        end
    end

    initial begin
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        tb_v      = '0;
        for (int i = 0; i < N; i++) begin
            tb_a[i] = '0;
            tb_b[i] = '0;
            pend[i] = 0;
        end
        #1;
        do_reset();
        mon_en = 1;
        cycle_go();
        check("sub_ce_after_reset", longint'(sub_ce), 1);

        // All requesters active: strict 0,1,2,3 rotation twice
        tb_v = '1;
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < N; i++) begin
                tb_a[i] = rand_op();
                tb_b[i] = rand_op();
            end
            cycle_go();
        end
        tb_v = '0;

        // Single request from requester 2
        tb_v = 4'b0100; tb_a[2] = 16'h0010; tb_b[2] = 16'h0003;
        cycle_go();

        // Pointer now at 3: requester 3 beats requester 1
        tb_v = 4'b1010;
        tb_a[1] = 16'h1234; tb_b[1] = 16'h1235;
        tb_a[3] = 16'h8000; tb_b[3] = 16'h0001;
        cycle_go();
        tb_v = 4'b0010;
        cycle_go();

        // Pointer now at 2
        tb_v = '1;
        cycle_go();
        tb_v = '0;

        // Wrap-around subtraction
        tb_v = 4'b0001; tb_a[0] = 16'h0000; tb_b[0] = 16'h0001;
        cycle_go();
        tb_v = '0;

        // Idle
        repeat (10) cycle_go();
        check("idle_sub_ce", longint'(sub_ce), 1);
        check("idle_busy", longint'(busy), 0);
        check("idle_resp_valid", longint'(resp_valid), 0);

        // Random traffic: requests hold valid until granted
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 9) < 4) begin
                    pend[i] = 1;
                    tb_a[i] = rand_op();
                    tb_b[i] = rand_op();
                end
                tb_v[i] = pend[i];
            end
            cycle_go();
            if (granted >= 0) pend[granted] = 0;
        end
        for (int i = 0; i < N; i++) pend[i] = 0;
        tb_v = '0;
        for (int i = 0; i < 20 && sb.size() > 0; i++) cycle_go();
        check("drain_random", longint'(sb.size()), 0);

        // Reset with three operations in flight
        tb_v = 4'b0111;
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < N; i++) begin
                tb_a[i] = rand_op();
                tb_b[i] = rand_op();
            end
            cycle_go();
        end
        do_reset();
        repeat (6) cycle_go();
        check("post_reset_busy", longint'(busy), 0);
        check("post_reset_resp_valid", longint'(resp_valid), 0);

        // First request after reset is the first response
        tb_v = 4'b1000; tb_a[3] = 16'h00FF; tb_b[3] = 16'h0F00;
        cycle_go();
        tb_v = '0;
        for (int i = 0; i < 20 && sb.size() > 0; i++) cycle_go();
        check("drain_final", longint'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
